// File: rtl/fwd_ctrl_unit.sv
// Operand forwarding and load-use stall control with a short retired-result history.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_ctrl_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_d,
    input  logic [AW-1:0]    rs2_d,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic             wr_en_e,
    input  logic [AW-1:0]    rd_e,
    input  logic             load_e,
    input  logic [WIDTH-1:0] alu_result_e,
    input  logic [WIDTH-1:0] load_data_m,
    output logic [WIDTH-1:0] SrcAE,
    output logic [WIDTH-1:0] SrcBE,
    output logic [2:0]       fwd_sel_a,
    output logic [2:0]       fwd_sel_b,
    output logic             stall_d,
    output logic [31:0]      stall_count,
    output logic [31:0]      fwd_count
);

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned NUM_SRC  = 2;
    localparam logic [2:0]  SEL_RF   = 3'd0;
    localparam logic [2:0]  SEL_EX   = 3'd1;
    localparam logic [2:0]  SEL_ZERO = 3'd7;

    typedef struct packed {
        logic             valid;
        logic             pending;
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } hist_t;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    hist_t  hist_q [DEPTH];
    hist_t  hist_d [DEPTH];
    state_t state_q;
    state_t state_d;

    logic [AW-1:0]    rs_c       [NUM_SRC];
    logic [WIDTH-1:0] rf_c       [NUM_SRC];
    logic [WIDTH-1:0] src_c      [NUM_SRC];
    logic [2:0]       sel_c      [NUM_SRC];
    logic [NUM_SRC-1:0] load_hit_c;

    // History shift; a load leaving entry 0 picks up its memory data on the way out.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            hist_d[k] = hist_q[k];
        end
        hist_d[0].valid   = wr_en_e && (rd_e != '0);
        hist_d[0].pending = wr_en_e && (rd_e != '0) && load_e;
        hist_d[0].rd      = rd_e;
        hist_d[0].data    = alu_result_e;
        for (int k = 1; k < int'(DEPTH); k++) begin
            hist_d[k] = hist_q[k-1];
            if (hist_q[k-1].pending) begin
                hist_d[k].data    = load_data_m;
                hist_d[k].pending = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '{default: '0};
        end else begin
            hist_q <= hist_d;
        end
    end

    // Per-source operand selection; the history loop runs oldest to youngest so the youngest hit wins.
    always_comb begin
        rs_c[0]    = rs1_d;
        rs_c[1]    = rs2_d;
        rf_c[0]    = rdata1;
        rf_c[1]    = rdata2;
        load_hit_c = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_c[i] = rf_c[i];
            sel_c[i] = SEL_RF;
            if (rs_c[i] == '0) begin
                src_c[i] = '0;
                sel_c[i] = SEL_ZERO;
            end else if (wr_en_e && (rd_e == rs_c[i])) begin
                if (load_e) begin
                    load_hit_c[i] = 1'b1;
                end else begin
                    src_c[i] = alu_result_e;
                    sel_c[i] = SEL_EX;
                end
            end else begin
                for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                    if (hist_q[k].valid && (hist_q[k].rd == rs_c[i])) begin
                        src_c[i] = hist_q[k].pending ? load_data_m : hist_q[k].data;
                        sel_c[i] = 3'(k + 2);
                    end
                end
            end
        end
    end

    assign SrcAE     = src_c[0];
    assign SrcBE     = src_c[1];
    assign fwd_sel_a = sel_c[0];
    assign fwd_sel_b = sel_c[1];

    // Stall FSM: one stall cycle per load-use, then a mandatory wait cycle.
    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        if (!rst && (state_q == RUN) && (|load_hit_c)) begin
            stall_d = 1'b1;
        end
        case (state_q)
            RUN:       if (stall_d) state_d = LOAD_WAIT;
            LOAD_WAIT: state_d = RUN;
            default:   state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;
    logic             fwd_any_c;

    always_comb begin
        fwd_any_c   = ((sel_c[0] != SEL_RF) && (sel_c[0] != SEL_ZERO)) ||
                      ((sel_c[1] != SEL_RF) && (sel_c[1] != SEL_ZERO));
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_d);
        fwd_cnt_d   = fwd_cnt_q + CNT_W'(fwd_any_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign fwd_count   = fwd_cnt_q;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Randomized bench for fwd_ctrl_unit against a cycle-log reference model, plus directed literal checks.
module tb_fwd_ctrl_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int NREC  = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [AW-1:0]    rs1_d, rs2_d, rd_e;
    logic [WIDTH-1:0] rdata1, rdata2, alu_result_e, load_data_m;
    logic             wr_en_e, load_e;
    logic [WIDTH-1:0] SrcAE, SrcBE;
    logic [2:0]       fwd_sel_a, fwd_sel_b;
    logic             stall_d;
    logic [31:0]      stall_count, fwd_count;

    always #5 clk = ~clk;

    fwd_ctrl_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rdata1(rdata1), .rdata2(rdata2),
        .wr_en_e(wr_en_e), .rd_e(rd_e), .load_e(load_e),
        .alu_result_e(alu_result_e), .load_data_m(load_data_m),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_d(stall_d), .stall_count(stall_count), .fwd_count(fwd_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Log of what the execute stage presented each cycle, indexed by cycle number.
    bit        rec_wr  [NREC];
    bit [4:0]  rec_rd  [NREC];
    bit        rec_ld  [NREC];
    bit [31:0] rec_alu [NREC];
    bit [31:0] rec_ldm [NREC];
    int        cyc      = 0;
    int        last_rst = -1;
    bit        prev_stall = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_fwd   = 0;
    logic [2:0] sa_q = '0, sb_q = '0;
    bit         es_q = 1'b0;

    // A result written k+1 cycles ago is visible if it survived since then; loads take the data seen one cycle later.
    function automatic void model_op(input logic [4:0] rs, input logic [31:0] rdata,
                                     output logic [31:0] v, output logic [2:0] sel, output bit hit);
        v = rdata; sel = 3'd0; hit = 1'b0;
        if (rs == 5'd0) begin v = 32'd0; sel = 3'd7; return; end
        if (wr_en_e && rd_e == rs) begin
            if (load_e) hit = 1'b1;
            else begin v = alu_result_e; sel = 3'd1; end
            return;
        end
        if (rst) return;
        for (int k = 0; k < DEPTH; k++) begin
            int c;
            c = cyc - 1 - k;
            if (c < 0 || c <= last_rst) return;
            if (rec_wr[c] && rec_rd[c] == rs) begin
                v   = !rec_ld[c] ? rec_alu[c] : (k == 0 ? load_data_m : rec_ldm[c+1]);
                sel = 3'(k + 2);
                return;
            end
        end
    endfunction

    always @(negedge clk) begin : compare
        logic [31:0] ea, eb;
        logic [2:0]  sa, sb;
        bit          ha, hb, es;
        model_op(rs1_d, rdata1, ea, sa, ha);
        model_op(rs2_d, rdata2, eb, sb, hb);
        es = (ha || hb) && !rst && !prev_stall;
        chk("SrcAE", SrcAE, ea);
        chk("SrcBE", SrcBE, eb);
        chk("fwd_sel_a", 32'(fwd_sel_a), 32'(sa));
        chk("fwd_sel_b", 32'(fwd_sel_b), 32'(sb));
        chk("stall_d", 32'(stall_d), 32'(es));
`ifdef FWD_PERF_CNT_EN
        chk("stall_count", stall_count, rst ? 32'd0 : 32'(m_stall));
        chk("fwd_count", fwd_count, rst ? 32'd0 : 32'(m_fwd));
`else
        chk("stall_count", stall_count, 32'd0);
        chk("fwd_count", fwd_count, 32'd0);
`endif
        sa_q <= sa;
        sb_q <= sb;
        es_q <= es;
    end

    always @(posedge clk) begin : model_commit
        rec_wr[cyc]  <= wr_en_e;
        rec_rd[cyc]  <= rd_e;
        rec_ld[cyc]  <= load_e;
        rec_alu[cyc] <= alu_result_e;
        rec_ldm[cyc] <= load_data_m;
        if (rst) begin
            last_rst   <= cyc;
            prev_stall <= 1'b0;
            m_stall    <= 0;
            m_fwd      <= 0;
        end else begin
            prev_stall <= es_q;
            m_stall    <= m_stall + 32'(es_q);
            if ((sa_q != 3'd0 && sa_q != 3'd7) || (sb_q != 3'd0 && sb_q != 3'd7))
                m_fwd <= m_fwd + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic idle();
        rs1_d = '0; rs2_d = '0; rd_e = '0;
        wr_en_e = 1'b0; load_e = 1'b0;
        rdata1 = 32'h1111; rdata2 = 32'h2222;
        alu_result_e = '0; load_data_m = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rs1_d = 5'd7;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_stall", 32'(stall_d), 32'd0);
        chk("rst_srca", SrcAE, 32'h1111);
        chk("rst_cnt", stall_count | fwd_count, 32'd0);

        // Load-use: stall, then forward from pending entry 0, then from entry 1.
        next_cycle(); rst = 1'b0;
        wr_en_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; #2;
        chk("lu_stall", 32'(stall_d), 32'd1);
        chk("lu_sel0", 32'(fwd_sel_a), 32'd0);
        chk("lu_srca0", SrcAE, 32'h1111);
        next_cycle(); load_data_m = 32'hCAFE; rs1_d = 5'd7; #2;
        chk("lu_srca1", SrcAE, 32'hCAFE);
        chk("lu_sel1", 32'(fwd_sel_a), 32'd2);
        chk("lu_nostall", 32'(stall_d), 32'd0);
        next_cycle(); rs1_d = 5'd7; #2;
        chk("lu_srca2", SrcAE, 32'hCAFE);
        chk("lu_sel2", 32'(fwd_sel_a), 32'd3);
`ifdef FWD_PERF_CNT_EN
        chk("lu_stall_count", stall_count, 32'd1);
        chk("lu_fwd_count", fwd_count, 32'd1);
`else
        chk("lu_stall_count", stall_count, 32'd0);
        chk("lu_fwd_count", fwd_count, 32'd0);
`endif

        // ALU chain then history hit.
        next_cycle(); wr_en_e = 1'b1; rd_e = 5'd5; alu_result_e = 32'h10; rs1_d = 5'd5; #2;
        chk("alu_srca", SrcAE, 32'h10);
        chk("alu_sel", 32'(fwd_sel_a), 32'd1);
        chk("alu_stall", 32'(stall_d), 32'd0);
        next_cycle(); rs2_d = 5'd5; rdata2 = 32'hDEAD; #2;
        chk("hist_srcb", SrcBE, 32'h10);
        chk("hist_sel", 32'(fwd_sel_b), 32'd2);

        // Execute beats history; x0 reads zero.
        next_cycle(); wr_en_e = 1'b1; rd_e = 5'd3; alu_result_e = 32'h1;
        next_cycle(); wr_en_e = 1'b1; rd_e = 5'd3; alu_result_e = 32'h2; rs1_d = 5'd3; rs2_d = 5'd3; #2;
        chk("prio_srca", SrcAE, 32'h2);
        chk("prio_srcb", SrcBE, 32'h2);
        chk("prio_sel", 32'({fwd_sel_a, fwd_sel_b}), 32'(6'o11));
        next_cycle(); wr_en_e = 1'b1; rd_e = 5'd0; alu_result_e = 32'h55; rs1_d = 5'd0; #2;
        chk("x0_srca", SrcAE, 32'd0);
        chk("x0_sel", 32'(fwd_sel_a), 32'd7);

        // Reset while waiting on a load.
        next_cycle(); wr_en_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; #2;
        chk("rw_stall", 32'(stall_d), 32'd1);
        next_cycle(); rs1_d = 5'd7; rdata1 = 32'h3333; #1; rst = 1'b1; #1;
        chk("rw_nostall", 32'(stall_d), 32'd0);
        chk("rw_srca", SrcAE, 32'h3333);
        chk("rw_cnt", stall_count | fwd_count, 32'd0);
        next_cycle(); rst = 1'b0; wr_en_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; #2;
        chk("rw_run_stall", 32'(stall_d), 32'd1);
        next_cycle();

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            rst          = ($urandom_range(0, 199) == 0);
            wr_en_e      = ($urandom_range(0, 9) < 7);
            load_e       = ($urandom_range(0, 3) == 0);
            rd_e         = 5'($urandom_range(0, 7));
            rs1_d        = 5'($urandom_range(0, 7));
            rs2_d        = 5'($urandom_range(0, 7));
            rdata1       = $urandom;
            rdata2       = $urandom;
            alu_result_e = $urandom;
            load_data_m  = $urandom;
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
